// File: rtl/maple_rx_ctrl_if.sv
// Bundle of the Maple receiver link, the packet header handshake and the statistics readout.
// The master modport is the receive sequencer; the slave modport is its environment.
interface maple_rx_ctrl_if;
    logic        rx_trigger_start;
    logic        rx_start_detected;
    logic        rx_end_detected;
    logic [7:0]  rx_data;
    logic        rx_data_produce;

    logic        pkt_valid;
    logic        pkt_ready;
    logic [7:0]  pkt_frames;
    logic [7:0]  pkt_sender;
    logic [7:0]  pkt_recipient;
    logic [7:0]  pkt_command;
    logic [7:0]  pkt_func;

    logic [15:0] stat_ok;
    logic [15:0] stat_err;
    logic [15:0] stat_overrun;

    modport master (
        output rx_trigger_start,
        input  rx_start_detected,
        input  rx_end_detected,
        input  rx_data,
        input  rx_data_produce,
        output pkt_valid,
        input  pkt_ready,
        output pkt_frames,
        output pkt_sender,
        output pkt_recipient,
        output pkt_command,
        output pkt_func,
        output stat_ok,
        output stat_err,
        output stat_overrun
    );

    modport slave (
        input  rx_trigger_start,
        output rx_start_detected,
        output rx_end_detected,
        output rx_data,
        output rx_data_produce,
        input  pkt_valid,
        output pkt_ready,
        input  pkt_frames,
        input  pkt_sender,
        input  pkt_recipient,
        input  pkt_command,
        input  pkt_func,
        input  stat_ok,
        input  stat_err,
        input  stat_overrun
    );
endinterface

// File: rtl/maple_rx_ctrl.sv
// Maple bus receive sequencer: arms the receiver, frames the byte stream, validates the
// length against the frame-count header, enforces a watchdog and hands headers downstream.
module maple_rx_ctrl #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int REARM_GAP      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    maple_rx_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_START,
        RECEIVE,
        CHECK,
        GAP
    } state_t;

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = (REARM_GAP > 1) ? $clog2(REARM_GAP) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REARM_GAP - 1);
    localparam logic [10:0]      BYTE_MAX = 11'h7FF;

    state_t            state_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [10:0]       byte_cnt_reg;
    logic [7:0]        hdr_reg [0:4];

    logic              trigger_reg;
    logic              valid_reg;
    logic [7:0]        frames_reg;
    logic [7:0]        sender_reg;
    logic [7:0]        recipient_reg;
    logic [7:0]        command_reg;
    logic [7:0]        func_reg;
    logic [15:0]       ok_reg;
    logic [15:0]       err_reg;
    logic [15:0]       ovr_reg;

    logic [10:0]       expected_len;
    logic              len_ok;
    logic              capture;
    logic              timeout_hit;

    // 4 + 4*N always fits in 11 bits (max 1024 for N = 255).
    assign expected_len = 11'd4 + {1'b0, hdr_reg[0], 2'b00};
    assign len_ok       = (byte_cnt_reg == expected_len);
    assign capture      = bus.rx_data_produce && ((state_reg == WAIT_START) || (state_reg == RECEIVE));
    assign timeout_hit  = (to_cnt_reg == TO_LAST);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            to_cnt_reg    <= '0;
            gap_cnt_reg   <= '0;
            byte_cnt_reg  <= '0;
            for (int i = 0; i < 5; i++) hdr_reg[i] <= '0;
            trigger_reg   <= 1'b0;
            valid_reg     <= 1'b0;
            frames_reg    <= '0;
            sender_reg    <= '0;
            recipient_reg <= '0;
            command_reg   <= '0;
            func_reg      <= '0;
            ok_reg        <= '0;
            err_reg       <= '0;
            ovr_reg       <= '0;
        end else begin
            trigger_reg <= 1'b0;
            // A commit in CHECK below overrides this consumption.
            if (valid_reg && bus.pkt_ready) valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    state_reg   <= ARM;
                    trigger_reg <= 1'b1;
                end
                ARM: begin
                    byte_cnt_reg <= '0;
                    to_cnt_reg   <= '0;
                    for (int i = 0; i < 5; i++) hdr_reg[i] <= '0;
                    state_reg    <= WAIT_START;
                end
                WAIT_START: begin
                    if (bus.rx_start_detected || bus.rx_data_produce) begin
                        state_reg  <= RECEIVE;
                        to_cnt_reg <= '0;
                    end else if (bus.rx_end_detected) begin
                        state_reg <= CHECK;
                    end else if (timeout_hit) begin
                        state_reg   <= GAP;
                        gap_cnt_reg <= '0;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end
                RECEIVE: begin
                    if (bus.rx_end_detected) begin
                        state_reg <= CHECK;
                    end else if (bus.rx_data_produce) begin
                        to_cnt_reg <= '0;
                    end else if (timeout_hit) begin
                        state_reg   <= GAP;
                        gap_cnt_reg <= '0;
                        err_reg     <= sat_inc(err_reg);
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end
                CHECK: begin
                    state_reg   <= GAP;
                    gap_cnt_reg <= '0;
                    if (len_ok) begin
                        if (!valid_reg || bus.pkt_ready) begin
                            valid_reg     <= 1'b1;
                            frames_reg    <= hdr_reg[0];
                            sender_reg    <= hdr_reg[1];
                            recipient_reg <= hdr_reg[2];
                            command_reg   <= hdr_reg[3];
                            func_reg      <= (hdr_reg[0] == 8'd0) ? 8'd0 : hdr_reg[4];
                            ok_reg        <= sat_inc(ok_reg);
                        end else begin
                            ovr_reg <= sat_inc(ovr_reg);
                        end
                    end else begin
                        err_reg <= sat_inc(err_reg);
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg   <= ARM;
                        trigger_reg <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Only WAIT_START/RECEIVE capture, so this never collides with the ARM clear.
            if (capture) begin
                if (byte_cnt_reg < 11'd5) hdr_reg[byte_cnt_reg[2:0]] <= bus.rx_data;
                if (byte_cnt_reg != BYTE_MAX) byte_cnt_reg <= byte_cnt_reg + 11'd1;
            end
        end
    end

    assign bus.rx_trigger_start = trigger_reg;
    assign bus.pkt_valid        = valid_reg;
    assign bus.pkt_frames       = frames_reg;
    assign bus.pkt_sender       = sender_reg;
    assign bus.pkt_recipient    = recipient_reg;
    assign bus.pkt_command      = command_reg;
    assign bus.pkt_func         = func_reg;
    assign bus.stat_ok          = ok_reg;
    assign bus.stat_err         = err_reg;
    assign bus.stat_overrun     = ovr_reg;

endmodule

// File: tb/tb_maple_rx_ctrl.sv
// Randomized bench for maple_rx_ctrl against a packet-level model of outcomes,
// held-header contents, statistics and re-arm timing.
module tb_maple_rx_ctrl;

    localparam int T = 100;
    localparam int G = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    maple_rx_ctrl_if bus();

    maple_rx_ctrl #(.TIMEOUT_CYCLES(T), .REARM_GAP(G)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int txn_no = 0;
    int arm_cyc = 0;

    // Packet-level model
    logic [7:0]  pbytes[$];
    logic        m_valid = 1'b0;
    logic [7:0]  m_pkt[5];
    logic [15:0] m_ok = '0, m_err = '0, m_ovr = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (txn %0d, cycle %0d)", tag, got, exp, txn_no, cyc);
        end
    endtask

    task automatic drive(input logic st, input logic en, input logic pr, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.rx_start_detected = st;
        bus.rx_end_detected   = en;
        bus.rx_data_produce   = pr;
        bus.rx_data           = d;
    endtask

    task automatic wait_neg_of(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic wait_arm(input int exp_cyc);
        int  n = 0;
        bit  seen = 0;
        while (!seen && n < T + G + 50) begin
            @(negedge clk);
            n++;
            if (bus.rx_trigger_start) seen = 1;
        end
        check_val("arm_seen", {31'd0, seen}, 32'd1);
        if (seen) check_val("arm_cycle", cyc, exp_cyc);
        arm_cyc = cyc;
        @(negedge clk);
        check_val("arm_one_cycle", {31'd0, bus.rx_trigger_start}, 32'd0);
    endtask

    task automatic check_state();
        check_val("pkt_valid", {31'd0, bus.pkt_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check_val("pkt_frames",    bus.pkt_frames,    m_pkt[0]);
            check_val("pkt_sender",    bus.pkt_sender,    m_pkt[1]);
            check_val("pkt_recipient", bus.pkt_recipient, m_pkt[2]);
            check_val("pkt_command",   bus.pkt_command,   m_pkt[3]);
            check_val("pkt_func",      bus.pkt_func,      m_pkt[4]);
        end
        check_val("stat_ok",      bus.stat_ok,      m_ok);
        check_val("stat_err",     bus.stat_err,     m_err);
        check_val("stat_overrun", bus.stat_overrun, m_ovr);
    endtask

    // kind 0: framed packet from pbytes; 1: start + pbytes then silence; 2: no activity.
    // mode 0: ready low; 1: ready high from arm; 2: ready rises in the commit cycle.
    task automatic run_txn(input int kind, input int mode, input bit use_start);
        int  t, b, exp_arm;
        bit  good;
        txn_no++;
        bus.pkt_ready = (mode == 1);
        if (mode == 1) m_valid = 1'b0;
        exp_arm = 0;
        good = 0;
        case (kind)
            0: begin
                if (use_start) drive(1, 0, 0, 8'h00);
                foreach (pbytes[i]) begin
                    drive(0, 0, 1, pbytes[i]);
                    repeat ($urandom_range(0, 2)) drive(0, 0, 0, 8'h00);
                end
                drive(0, 1, 0, 8'h00);
                t = cyc;
                drive(0, 0, 0, 8'h00);
                if (mode == 2) bus.pkt_ready = 1'b1;
                if (pbytes.size() > 0) good = (pbytes.size() == 4 + 4 * int'(pbytes[0]));
                if (good) begin
                    if (!m_valid || mode != 0) begin
                        m_pkt[0] = pbytes[0];
                        m_pkt[1] = pbytes[1];
                        m_pkt[2] = pbytes[2];
                        m_pkt[3] = pbytes[3];
                        m_pkt[4] = (pbytes[0] == 8'd0) ? 8'd0 : pbytes[4];
                        m_ok++;
                    end else begin
                        m_ovr++;
                    end
                    m_valid = 1'b1;
                end else begin
                    m_err++;
                    if (mode != 0) m_valid = 1'b0;
                end
                wait_neg_of(t + 2);
                check_state();
                if (mode != 0) begin
                    m_valid = 1'b0;
                    wait_neg_of(t + 3);
                    check_val("pkt_valid_drop", {31'd0, bus.pkt_valid}, 32'd0);
                end
                exp_arm = t + 2 + G;
            end
            1: begin
                drive(1, 0, 0, 8'h00);
                b = cyc;
                foreach (pbytes[i]) begin
                    drive(0, 0, 1, pbytes[i]);
                    b = cyc;
                end
                drive(0, 0, 0, 8'h00);
                m_err++;
                exp_arm = b + T + 1 + G;
            end
            default: begin
                exp_arm = arm_cyc + T + 1 + G;
            end
        endcase
        wait_arm(exp_arm);
        check_state();
        $display("txn %0d kind=%0d mode=%0d bytes=%0d good=%0d ok=%0d err=%0d ovr=%0d",
                 txn_no, kind, mode, pbytes.size(), good, m_ok, m_err, m_ovr);
    endtask

    task automatic make_packet(input bit want_good);
        int n, sz;
        n = $urandom_range(0, 3);
        if (want_good) sz = 4 + 4 * n;
        else begin
            do sz = $urandom_range(0, 20); while (sz == 4 + 4 * n);
        end
        pbytes.delete();
        for (int i = 0; i < sz; i++) pbytes.push_back(8'($urandom));
        if (sz > 0) pbytes[0] = 8'(n);
    endtask

    task automatic random_txns(input int count);
        int r;
        for (int k = 0; k < count; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                make_packet($urandom_range(0, 2) != 0);
                run_txn(0, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end else if (r < 85) begin
                pbytes.delete();
                repeat ($urandom_range(0, 3)) pbytes.push_back(8'($urandom));
                run_txn(1, $urandom_range(0, 1), 1'b1);
            end else begin
                pbytes.delete();
                run_txn(2, $urandom_range(0, 1), 1'b0);
            end
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ok = '0;
        m_err = '0;
        m_ovr = '0;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        bus.rx_start_detected = 1'b0;
        bus.rx_end_detected   = 1'b0;
        bus.rx_data_produce   = 1'b0;
        bus.rx_data           = 8'h00;
        bus.pkt_ready         = 1'b0;
        for (int i = 0; i < 5; i++) m_pkt[i] = 8'h00;

        repeat (3) @(negedge clk);
        check_val("rst_trigger", {31'd0, bus.rx_trigger_start}, 32'd0);
        check_val("rst_frames", bus.pkt_frames, 32'd0);
        check_val("rst_func", bus.pkt_func, 32'd0);
        check_state();
        rst_n = 1'b1;
        wait_arm(cyc + 1);

        // Controller packet, ready high
        pbytes = '{8'h03, 8'h20, 8'h00, 8'h08, 8'h01};
        repeat (11) pbytes.push_back(8'($urandom));
        run_txn(0, 1, 1'b1);
        // Length error: N = 3 with 12 bytes
        pbytes = '{8'h03};
        repeat (11) pbytes.push_back(8'($urandom));
        run_txn(0, 1, 1'b1);
        // Zero-frame packet
        pbytes = '{8'h00, 8'h20, 8'h00, 8'h07};
        run_txn(0, 1, 1'b0);
        // Backpressure: held, overrun, then replaced in commit cycle
        make_packet(1'b1);
        run_txn(0, 0, 1'b1);
        make_packet(1'b1);
        run_txn(0, 0, 1'b1);
        make_packet(1'b1);
        run_txn(0, 2, 1'b1);
        // Idle timeouts and a receive timeout after two bytes
        pbytes.delete();
        run_txn(2, 0, 1'b0);
        run_txn(2, 0, 1'b0);
        pbytes = '{8'h01, 8'h20};
        run_txn(1, 0, 1'b1);

        random_txns(40);

        // Reset mid-packet
        txn_no++;
        pbytes.delete();
        drive(1, 0, 0, 8'h00);
        drive(0, 0, 1, 8'h02);
        drive(0, 0, 1, 8'h20);
        @(posedge clk);
        #1;
        bus.rx_data_produce = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("mid_rst_trigger", {31'd0, bus.rx_trigger_start}, 32'd0);
        check_val("mid_rst_frames", bus.pkt_frames, 32'd0);
        check_val("mid_rst_sender", bus.pkt_sender, 32'd0);
        check_state();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_arm(cyc + 1);
        check_state();
        $display("txn %0d reset mid-packet ok=%0d err=%0d ovr=%0d", txn_no, m_ok, m_err, m_ovr);

        random_txns(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
